// File: rtl/scan_mux.sv
// scan_mux: registered N-channel mux, manual select or dwell-timed round-robin auto scan.
// Latency 1 cycle from sel/mode/data_in to outputs; no backpressure, a new selection is taken every cycle.
module scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [CHANNELS*WIDTH-1:0]    data_in,
  input  logic [SELW-1:0]              sel,
  input  logic                         mode,
  input  logic                         hold,
  output logic [WIDTH-1:0]             data_out,
  output logic [SELW-1:0]              chan_out,
  output logic                         wrap,
  output logic                         err
);

  localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW:0]   NCH      = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [SELW-1:0]  chan_out_q, chan_out_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             sel_ok;
  logic [SELW-1:0]  load_ch;

  // Indices with no matching channel read as zero.
  function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] idx,
                                            input logic [CHANNELS*WIDTH-1:0] bus);
    pick = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == SELW'(i)) begin
        pick = bus[i*WIDTH +: WIDTH];
      end
    end
  endfunction

  assign sel_ok  = ({1'b0, sel} < NCH);
  assign load_ch = sel_ok ? sel : '0;

  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    mode_d     = mode;
    data_out_d = data_out_q;
    chan_out_d = chan_out_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;

    if (!mode) begin
      chan_out_d = sel;
      data_out_d = sel_ok ? pick(sel, data_in) : '0;
      err_d      = ~sel_ok;
    end else if (!mode_q) begin
      // Fresh entry into auto: restart from the requested channel, ignoring hold.
      ptr_d      = load_ch;
      cnt_d      = '0;
      chan_out_d = load_ch;
      data_out_d = pick(load_ch, data_in);
    end else begin
      chan_out_d = ptr_q;
      data_out_d = pick(ptr_q, data_in);
      // Previous edge was also auto, so chan_out_q came from the scan itself.
      wrap_d     = (ptr_q == '0) && (chan_out_q == LAST_CH);
      if (!hold) begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + SELW'(1);
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      data_out_q <= '0;
      chan_out_q <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      data_out_q <= data_out_d;
      chan_out_q <= chan_out_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign data_out = data_out_q;
  assign chan_out = chan_out_q;
  assign wrap     = wrap_q;
  assign err      = err_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 4b/5ch/dwell-3 instance and an 8b/4ch/dwell-1 instance.
module tb_scan_mux;

  logic        clock;
  logic        resetn;
  logic [19:0] data_in;
  logic [2:0]  sel;
  logic        mode;
  logic        hold;
  logic [3:0]  data_out;
  logic [2:0]  chan_out;
  logic        wrap;
  logic        err;

  logic [31:0] data_in6;
  logic [1:0]  sel6;
  logic        mode6;
  logic        hold6;
  logic [7:0]  data_out6;
  logic [1:0]  chan_out6;
  logic        wrap6;
  logic        err6;

  int n_checks = 0;
  int n_fail   = 0;

  int t3_c [13] = '{3, 3, 3, 3, 4, 4, 4, 0, 0, 0, 1, 1, 1};
  int t3_d [13] = '{'hC, 'hC, 'hC, 'hC, 5, 5, 5, 'hA, 'hA, 'hA, 3, 3, 3};
  int t6_c [10] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0};

  scan_mux #(.WIDTH(4), .CHANNELS(5), .DWELL(3)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .data_in  (data_in),
    .sel      (sel),
    .mode     (mode),
    .hold     (hold),
    .data_out (data_out),
    .chan_out (chan_out),
    .wrap     (wrap),
    .err      (err)
  );

  scan_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) dut6 (
    .clock    (clock),
    .resetn   (resetn),
    .data_in  (data_in6),
    .sel      (sel6),
    .mode     (mode6),
    .hold     (hold6),
    .data_out (data_out6),
    .chan_out (chan_out6),
    .wrap     (wrap6),
    .err      (err6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn   = 1'b1;
    data_in  = 20'h5C73A;
    sel      = 3'd0;
    mode     = 1'b0;
    hold     = 1'b0;
    data_in6 = 32'h44332211;
    sel6     = 2'd0;
    mode6    = 1'b0;
    hold6    = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("rst_data", data_out, 0);
    check("rst_chan", chan_out, 0);
    check("rst_wrap", wrap, 0);
    check("rst_err",  err, 0);
    step();
    step();
    sel    = 3'd1;
    resetn = 1'b1;
    step();
    check("rel_data", data_out, 4'h3);
    check("rel_chan", chan_out, 1);

    // Manual selection, including an out-of-range select
    sel = 3'd2; step();
    check("man2_data", data_out, 4'h7);
    check("man2_chan", chan_out, 2);
    check("man2_err",  err, 0);
    sel = 3'd6; step();
    check("man6_data", data_out, 0);
    check("man6_chan", chan_out, 6);
    check("man6_err",  err, 1);
    sel = 3'd4; step();
    check("man4_data", data_out, 4'h5);
    check("man4_err",  err, 0);

    // Auto scan from channel 3 through the wrap
    sel = 3'd3; mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      check($sformatf("t3_chan%0d", i), chan_out, t3_c[i]);
      check($sformatf("t3_data%0d", i), data_out, t3_d[i]);
      check($sformatf("t3_wrap%0d", i), wrap, (i == 7) ? 1 : 0);
      check($sformatf("t3_err%0d", i),  err, 0);
    end

    // Out-of-range start falls back to channel 0 with no wrap on entry
    mode = 1'b0; sel = 3'd7; step();
    check("t3b_man_err", err, 1);
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t3b_chan%0d", i), chan_out, (i < 4) ? 0 : 1);
      check($sformatf("t3b_wrap%0d", i), wrap, 0);
      check($sformatf("t3b_err%0d", i),  err, 0);
    end

    // Asynchronous reset between edges while scanning
    resetn = 1'b0;
    #1;
    check("arst_data", data_out, 0);
    check("arst_chan", chan_out, 0);
    check("arst_wrap", wrap, 0);
    check("arst_err",  err, 0);
    mode = 1'b0; sel = 3'd1;
    #1 resetn = 1'b1;
    step();
    check("arst_rel_data", data_out, 4'h3);
    check("arst_rel_chan", chan_out, 1);

    // Hold mid-dwell on channel 2, with live data change during the hold
    sel = 3'd2; mode = 1'b1;
    step(); check("h_e1_chan", chan_out, 2);
    step(); check("h_e2_chan", chan_out, 2);
    hold = 1'b1;
    step(); check("h_e3_chan", chan_out, 2); check("h_e3_data", data_out, 4'h7);
    step(); check("h_e4_chan", chan_out, 2);
    data_in[11:8] = 4'hE;
    step(); check("h_e5_chan", chan_out, 2); check("h_e5_data", data_out, 4'hE);
    step(); check("h_e6_chan", chan_out, 2);
    step(); check("h_e7_chan", chan_out, 2);
    hold = 1'b0;
    step(); check("h_e8_chan", chan_out, 2);
    step(); check("h_e9_chan", chan_out, 2);
    step(); check("h_e10_chan", chan_out, 3); check("h_e10_data", data_out, 4'hC);

    // Auto to manual mid-dwell, then re-entry on channel 1
    step(); check("am_chan3", chan_out, 3);
    mode = 1'b0; sel = 3'd1;
    step();
    check("am_data", data_out, 4'h3);
    check("am_chan", chan_out, 1);
    check("am_err",  err, 0);
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("re_chan%0d", i), chan_out, (i < 4) ? 1 : 2);
      check($sformatf("re_data%0d", i), data_out, (i < 4) ? 4'h3 : 4'hE);
    end

    // Second instance: power-of-two channels, dwell of one
    for (int s = 0; s < 4; s++) begin
      sel6 = 2'(s);
      step();
      check($sformatf("t6_man_data%0d", s), data_out6, 8'h11 * (s + 1));
      check($sformatf("t6_man_err%0d", s),  err6, 0);
    end
    sel6 = 2'd0; mode6 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t6_chan%0d", i), chan_out6, t6_c[i]);
      check($sformatf("t6_data%0d", i), data_out6, 8'h11 * (t6_c[i] + 1));
      check($sformatf("t6_wrap%0d", i), wrap6, (i == 5 || i == 9) ? 1 : 0);
      check($sformatf("t6_err%0d", i),  err6, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
